// File: rtl/branch_mdr_pc_unit_pkg.sv
// Shared constants for the branch/MDR/PC datapath slice: C2 condition encodings
// and the position of the C2 field inside the instruction register.
package branch_mdr_pc_unit_pkg;

    localparam logic [1:0] C2_BRZR = 2'b00;
    localparam logic [1:0] C2_BRNZ = 2'b01;
    localparam logic [1:0] C2_BRPL = 2'b10;
    localparam logic [1:0] C2_BRMI = 2'b11;

    localparam int C2_LSB = 19;
    localparam int C2_MSB = 20;

endpackage

// File: rtl/branch_mdr_pc_unit_cond_eval.sv
// Combinational branch condition: decides "taken" from the C2 field and a bus value.
// Kept standalone so the control unit can reuse it for debug visibility.
module branch_cond_eval
    import branch_mdr_pc_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [1:0]            c2,
    input  logic [DATA_WIDTH-1:0] value,
    output logic                  taken
);

    // brpl treats zero as positive, so it only looks at the sign bit
    always_comb begin
        taken = 1'b0;
        case (c2)
            C2_BRZR: taken = (value == '0);
            C2_BRNZ: taken = (value != '0);
            C2_BRPL: taken = ~value[DATA_WIDTH-1];
            C2_BRMI: taken = value[DATA_WIDTH-1];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_mdr_pc_unit.sv
// Datapath support block: CON flip-flop, memory data register and registered
// PC incrementer. All outputs are registered; clr is synchronous and dominant.
module branch_mdr_pc_unit
    import branch_mdr_pc_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int PC_STEP    = 1
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  con_in,
    input  logic [DATA_WIDTH-1:0] ir_in,
    input  logic [DATA_WIDTH-1:0] bus_in,
    output logic                  branch_flag,
    input  logic                  mdr_in,
    input  logic                  read,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic [DATA_WIDTH-1:0] mdr_out,
    input  logic                  inc_pc,
    input  logic [DATA_WIDTH-1:0] pc_in,
    output logic [DATA_WIDTH-1:0] pc_next,
    output logic                  pc_next_valid
);

    logic [1:0] c2;
    logic       taken;
    logic       unused_ir;

    assign c2        = ir_in[C2_MSB:C2_LSB];
    assign unused_ir = ^{ir_in[DATA_WIDTH-1:C2_MSB+1], ir_in[C2_LSB-1:0]};

    branch_cond_eval #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_cond_eval (
        .c2   (c2),
        .value(bus_in),
        .taken(taken)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            branch_flag <= 1'b0;
        end else if (con_in) begin
            branch_flag <= taken;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            mdr_out <= '0;
        end else if (mdr_in) begin
            mdr_out <= read ? mem_data_in : bus_in;
        end
    end

    // Sum is truncated to the bus width, so the all-ones PC wraps to zero
    always_ff @(posedge clk) begin
        if (clr) begin
            pc_next       <= '0;
            pc_next_valid <= 1'b0;
        end else begin
            pc_next_valid <= inc_pc;
            if (inc_pc) begin
                pc_next <= pc_in + DATA_WIDTH'(PC_STEP);
            end
        end
    end

endmodule

// File: tb/tb_branch_mdr_pc_unit.sv
// Scoreboard bench for branch_mdr_pc_unit: directed vectors push hand-computed
// expectations; a monitor pops one entry per clock edge and compares.
module tb_branch_mdr_pc_unit;

    localparam int W = 32;

    typedef struct {
        string        tag;
        logic         bf;
        logic [W-1:0] mdr;
        logic [W-1:0] pcn;
        logic         pcv;
        logic [W-1:0] pcn4;
        logic         pcv4;
    } exp_t;

    logic         clk = 1'b0;
    logic         clr = 1'b0;
    logic         con_in = 1'b0;
    logic [W-1:0] ir_in = '0;
    logic [W-1:0] bus_in = '0;
    logic         mdr_in = 1'b0;
    logic         read = 1'b0;
    logic [W-1:0] mem_data_in = '0;
    logic         inc_pc = 1'b0;
    logic [W-1:0] pc_in = '0;
    logic         inc_pc4 = 1'b0;
    logic [W-1:0] pc_in4 = '0;

    logic         branch_flag, branch_flag4;
    logic [W-1:0] mdr_out, mdr_out4;
    logic [W-1:0] pc_next, pc_next4;
    logic         pc_next_valid, pc_next_valid4;

    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    bit   stim_done = 1'b0;

    always #5 clk = ~clk;

    branch_mdr_pc_unit #(.DATA_WIDTH(W), .PC_STEP(1)) u_dut (
        .clk          (clk),
        .clr          (clr),
        .con_in       (con_in),
        .ir_in        (ir_in),
        .bus_in       (bus_in),
        .branch_flag  (branch_flag),
        .mdr_in       (mdr_in),
        .read         (read),
        .mem_data_in  (mem_data_in),
        .mdr_out      (mdr_out),
        .inc_pc       (inc_pc),
        .pc_in        (pc_in),
        .pc_next      (pc_next),
        .pc_next_valid(pc_next_valid)
    );

    branch_mdr_pc_unit #(.DATA_WIDTH(W), .PC_STEP(4)) u_dut4 (
        .clk          (clk),
        .clr          (clr),
        .con_in       (con_in),
        .ir_in        (ir_in),
        .bus_in       (bus_in),
        .branch_flag  (branch_flag4),
        .mdr_in       (mdr_in),
        .read         (read),
        .mem_data_in  (mem_data_in),
        .mdr_out      (mdr_out4),
        .inc_pc       (inc_pc4),
        .pc_in        (pc_in4),
        .pc_next      (pc_next4),
        .pc_next_valid(pc_next_valid4)
    );

    task automatic applyStimulus(
        input string        tag,
        input logic         c, input logic cn, input logic [1:0] c2, input logic [W-1:0] bus,
        input logic         md, input logic rd, input logic [W-1:0] mem,
        input logic         inc, input logic [W-1:0] pc,
        input logic         inc4, input logic [W-1:0] pc4,
        input logic         e_bf, input logic [W-1:0] e_mdr,
        input logic [W-1:0] e_pcn, input logic e_pcv,
        input logic [W-1:0] e_pcn4, input logic e_pcv4
    );
        exp_t e;
        @(negedge clk);
        clr         = c;
        con_in      = cn;
        ir_in       = 32'h5A5A_5A5A;
        ir_in[20:19] = c2;
        bus_in      = bus;
        mdr_in      = md;
        read        = rd;
        mem_data_in = mem;
        inc_pc      = inc;
        pc_in       = pc;
        inc_pc4     = inc4;
        pc_in4      = pc4;
        e.tag  = tag;
        e.bf   = e_bf;
        e.mdr  = e_mdr;
        e.pcn  = e_pcn;
        e.pcv  = e_pcv;
        e.pcn4 = e_pcn4;
        e.pcv4 = e_pcv4;
        exp_q.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        vectors++;
        if (branch_flag !== e.bf) begin
            miscompares++;
            $display("[TB] FAIL %s branch_flag got %0b want %0b", e.tag, branch_flag, e.bf);
        end
        if (mdr_out !== e.mdr) begin
            miscompares++;
            $display("[TB] FAIL %s mdr_out got %h want %h", e.tag, mdr_out, e.mdr);
        end
        if (pc_next !== e.pcn) begin
            miscompares++;
            $display("[TB] FAIL %s pc_next got %h want %h", e.tag, pc_next, e.pcn);
        end
        if (pc_next_valid !== e.pcv) begin
            miscompares++;
            $display("[TB] FAIL %s pc_next_valid got %0b want %0b", e.tag, pc_next_valid, e.pcv);
        end
        if (pc_next4 !== e.pcn4) begin
            miscompares++;
            $display("[TB] FAIL %s pc_next(step4) got %h want %h", e.tag, pc_next4, e.pcn4);
        end
        if (pc_next_valid4 !== e.pcv4) begin
            miscompares++;
            $display("[TB] FAIL %s pc_next_valid(step4) got %0b want %0b", e.tag, pc_next_valid4, e.pcv4);
        end
    endtask

    // Outputs are registered, so every edge presents a fresh result
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        //             tag         clr con c2     bus           mdr rd mem           inc pc            inc4 pc4           bf mdr           pcn           pcv pcn4          pcv4
        applyStimulus("rst0",     1, 1, 2'b11, 32'hFFFF_FFFF, 1, 1, 32'hA5A5_A5A5, 1, 32'h77,        1, 32'h55,        0, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("rst1",     1, 1, 2'b00, 32'h0,         1, 0, 32'h1234_5678, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 0, 32'h0,        32'h0,        0, 32'h0,        0);

        applyStimulus("brzr_0",   0, 1, 2'b00, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("brzr_5",   0, 1, 2'b00, 32'h5,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("brzr_neg", 0, 1, 2'b00, 32'h8000_0000, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("brnz_0",   0, 1, 2'b01, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("brnz_5",   0, 1, 2'b01, 32'h5,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("brnz_neg", 0, 1, 2'b01, 32'h8000_0000, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("brpl_0",   0, 1, 2'b10, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("brpl_5",   0, 1, 2'b10, 32'h5,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("brpl_neg", 0, 1, 2'b10, 32'h8000_0000, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("brmi_0",   0, 1, 2'b11, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("brmi_5",   0, 1, 2'b11, 32'h5,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         0, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("brmi_neg", 0, 1, 2'b11, 32'h8000_0000, 0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("con_hold", 0, 0, 2'b11, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("con_hold2",0, 0, 2'b00, 32'h5,         0, 0, 32'h0,         0, 32'h0,         0, 32'h0,         1, 32'h0,        32'h0,        0, 32'h0,        0);

        applyStimulus("mdr_mem",  0, 0, 2'b00, 32'h0,         1, 1, 32'hDEAD_BEEF, 0, 32'h0,         0, 32'h0,         1, 32'hDEAD_BEEF, 32'h0,       0, 32'h0,        0);
        applyStimulus("mdr_bus",  0, 0, 2'b00, 32'h1234,      1, 0, 32'hDEAD_BEEF, 0, 32'h0,         0, 32'h0,         1, 32'h0000_1234, 32'h0,       0, 32'h0,        0);
        applyStimulus("mdr_hold", 0, 0, 2'b00, 32'hCAFE,      0, 1, 32'hFFFF_FFFF, 0, 32'h0,         0, 32'h0,         1, 32'h0000_1234, 32'h0,       0, 32'h0,        0);

        applyStimulus("pc_inc",   0, 0, 2'b00, 32'h0,         0, 0, 32'h0,         1, 32'h10,        0, 32'h0,         1, 32'h1234,     32'h11,       1, 32'h0,        0);
        applyStimulus("pc_hold",  0, 0, 2'b00, 32'h0,         0, 0, 32'h0,         0, 32'h20,        0, 32'h0,         1, 32'h1234,     32'h11,       0, 32'h0,        0);
        applyStimulus("pc_wrap",  0, 0, 2'b00, 32'h0,         0, 0, 32'h0,         1, 32'hFFFF_FFFF, 0, 32'h0,         1, 32'h1234,     32'h0,        1, 32'h0,        0);
        applyStimulus("pc_idle",  0, 0, 2'b00, 32'h0,         0, 0, 32'h0,         0, 32'h3,         0, 32'h0,         1, 32'h1234,     32'h0,        0, 32'h0,        0);
        applyStimulus("pc4_inc",  0, 0, 2'b00, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'h8,         1, 32'h1234,     32'h0,        0, 32'hC,        1);
        applyStimulus("pc4_hold", 0, 0, 2'b00, 32'h0,         0, 0, 32'h0,         0, 32'h0,         0, 32'h40,        1, 32'h1234,     32'h0,        0, 32'hC,        0);
        applyStimulus("pc4_wrap", 0, 0, 2'b00, 32'h0,         0, 0, 32'h0,         0, 32'h0,         1, 32'hFFFF_FFFC, 1, 32'h1234,     32'h0,        0, 32'h0,        1);

        applyStimulus("all_en",   0, 1, 2'b00, 32'h7,         1, 0, 32'h9999_9999, 1, 32'h100,       0, 32'h0,         0, 32'h7,        32'h101,      1, 32'h0,        0);
        applyStimulus("held_en",  0, 1, 2'b01, 32'h7,         1, 1, 32'h0BAD_F00D, 1, 32'h5,         0, 32'h0,         1, 32'h0BAD_F00D, 32'h6,       1, 32'h0,        0);
        applyStimulus("held_en2", 0, 1, 2'b01, 32'h0,         1, 0, 32'h0,         1, 32'h9,         1, 32'h8,         0, 32'h0,        32'hA,        1, 32'hC,        1);
        applyStimulus("all_clr",  1, 1, 2'b01, 32'h7,         1, 1, 32'hFFFF_FFFF, 1, 32'h100,       1, 32'h8,         0, 32'h0,        32'h0,        0, 32'h0,        0);
        applyStimulus("clr_hold", 0, 0, 2'b01, 32'h7,         0, 1, 32'hFFFF_FFFF, 0, 32'h100,       0, 32'h8,         0, 32'h0,        32'h0,        0, 32'h0,        0);

        @(negedge clk);
        con_in  = 1'b0;
        mdr_in  = 1'b0;
        inc_pc  = 1'b0;
        inc_pc4 = 1'b0;
        clr     = 1'b0;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        #2;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain %0d entries left, want 0", exp_q.size());
        end
        stim_done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        if (!stim_done) begin
            $display("[TB] FAIL timeout got no completion want completion");
            $fatal(1, "[TB] timeout");
        end
    end

endmodule
